alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for a multi-cycle RV32IM core: fetches, decodes to ALU op codes,
// waits on the registered ALU or the memory handshake, then writes back and advances the PC.
module alu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_CODE = 32'd63,
    parameter int unsigned TIMEOUT  = 40
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_IR_valid,
    input  logic [31:0] i_IR,
    output logic        o_fetch_req,
    output logic [31:0] o_PC,
    output logic [31:0] o_instruction,
    output logic [31:0] o_IR,
    output logic        o_state,
    input  logic        i_alu_load_regfile,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_jump_DV,
    input  logic [31:0] i_alu_jump_address,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic        o_rd_we,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_mem_req,
    input  logic        i_mem_done,
    output logic        o_illegal
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     next_pc_q, next_pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic [5:0]      code_q, code_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  dec_code;
    logic        dec_ok;
    logic        dec_mem;
    logic        exec_branch;
    logic        exec_jump;
    logic        exec_done;
    logic [31:0] pc_plus4;

    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign funct7   = ir_q[31:25];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        dec_code = 6'd0;
        dec_ok   = 1'b0;
        case (opcode)
            7'h33: begin
                if (funct7 == 7'h00) begin
                    dec_ok = 1'b1;
                    case (funct3)
                        3'd0:    dec_code = 6'd0;
                        3'd1:    dec_code = 6'd2;
                        3'd2:    dec_code = 6'd3;
                        3'd3:    dec_code = 6'd4;
                        3'd4:    dec_code = 6'd5;
                        3'd5:    dec_code = 6'd6;
                        3'd6:    dec_code = 6'd8;
                        default: dec_code = 6'd9;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    dec_ok   = 1'b1;
                    dec_code = 6'd1;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    dec_ok   = 1'b1;
                    dec_code = 6'd7;
                end else if (funct7 == 7'h01) begin
                    dec_ok   = 1'b1;
                    dec_code = 6'd10 + {3'd0, funct3};
                end
            end
            7'h13: begin
                case (funct3)
                    3'd0: begin dec_ok = 1'b1; dec_code = 6'd18; end
                    3'd2: begin dec_ok = 1'b1; dec_code = 6'd19; end
                    3'd3: begin dec_ok = 1'b1; dec_code = 6'd20; end
                    3'd4: begin dec_ok = 1'b1; dec_code = 6'd21; end
                    3'd6: begin dec_ok = 1'b1; dec_code = 6'd22; end
                    3'd7: begin dec_ok = 1'b1; dec_code = 6'd23; end
                    3'd1: begin
                        dec_ok   = (funct7 == 7'h00);
                        dec_code = 6'd24;
                    end
                    default: begin
                        dec_ok   = (funct7 == 7'h00) || (funct7 == 7'h20);
                        dec_code = (funct7 == 7'h20) ? 6'd26 : 6'd25;
                    end
                endcase
            end
            7'h03: begin
                case (funct3)
                    3'd0:    begin dec_ok = 1'b1; dec_code = 6'd27; end
                    3'd1:    begin dec_ok = 1'b1; dec_code = 6'd28; end
                    3'd2:    begin dec_ok = 1'b1; dec_code = 6'd29; end
                    3'd4:    begin dec_ok = 1'b1; dec_code = 6'd30; end
                    3'd5:    begin dec_ok = 1'b1; dec_code = 6'd31; end
                    default: ;
                endcase
            end
            7'h23: begin
                dec_ok   = (funct3 < 3'd3);
                dec_code = 6'd32 + {3'd0, funct3};
            end
            7'h63: begin
                case (funct3)
                    3'd0:    begin dec_ok = 1'b1; dec_code = 6'd35; end
                    3'd1:    begin dec_ok = 1'b1; dec_code = 6'd36; end
                    3'd4:    begin dec_ok = 1'b1; dec_code = 6'd37; end
                    3'd5:    begin dec_ok = 1'b1; dec_code = 6'd38; end
                    3'd6:    begin dec_ok = 1'b1; dec_code = 6'd39; end
                    3'd7:    begin dec_ok = 1'b1; dec_code = 6'd40; end
                    default: ;
                endcase
            end
            7'h6f: begin dec_ok = 1'b1; dec_code = 6'd41; end
            7'h67: begin dec_ok = (funct3 == 3'd0); dec_code = 6'd42; end
            7'h37: begin dec_ok = 1'b1; dec_code = 6'd43; end
            7'h17: begin dec_ok = 1'b1; dec_code = 6'd44; end
            default: ;
        endcase
    end

    assign dec_mem     = (dec_code >= 6'd27) && (dec_code <= 6'd34);
    assign exec_branch = (code_q >= 6'd35) && (code_q <= 6'd40);
    assign exec_jump   = (code_q == 6'd41) || (code_q == 6'd42);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        ir_d      = ir_q;
        rd_data_d = rd_data_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        illegal_d = illegal_q;
        exec_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_IR_valid) begin
                    ir_d    = i_IR;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                code_d    = dec_code;
                cnt_d     = '0;
                we_d      = 1'b0;
                next_pc_d = pc_plus4;
                if (!dec_ok) begin
                    illegal_d = 1'b1;
                    state_d   = StWb;
                end else if (dec_mem) begin
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            // Load data returns through the memory path, so MEM never writes rd here.
            StMem: begin
                if (i_mem_done) begin
                    state_d = StWb;
                end
            end
            StExec: begin
                cnt_d = cnt_q + CntW'(1);
                if (exec_branch) begin
                    if (cnt_q == CntW'(1)) begin
                        exec_done = 1'b1;
                        next_pc_d = i_alu_jump_DV ? i_alu_jump_address : pc_plus4;
                    end
                end else if (exec_jump) begin
                    if (i_alu_jump_DV && i_alu_load_regfile) begin
                        exec_done = 1'b1;
                        we_d      = 1'b1;
                        rd_data_d = i_alu_result;
                        next_pc_d = i_alu_jump_address;
                    end
                end else if (i_alu_load_regfile) begin
                    exec_done = 1'b1;
                    we_d      = 1'b1;
                    rd_data_d = i_alu_result;
                    next_pc_d = pc_plus4;
                end

                if (exec_done) begin
                    state_d = StWb;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    illegal_d = 1'b1;
                    next_pc_d = pc_plus4;
                    state_d   = StWb;
                end
            end
            StWb: begin
                pc_d    = next_pc_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            ir_q      <= '0;
            rd_data_q <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            ir_q      <= ir_d;
            rd_data_q <= rd_data_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_fetch_req   = (state_q == StIdle);
    assign o_PC          = pc_q;
    assign o_instruction = (state_q == StExec) ? {26'd0, code_q} : NOP_CODE;
    assign o_IR          = ir_q;
    assign o_state       = (state_q == StExec);
    assign o_rs1         = ir_q[19:15];
    assign o_rs2         = ir_q[24:20];
    assign o_rd_we       = (state_q == StWb) && we_q && (ir_q[11:7] != 5'd0);
    assign o_rd_addr     = ir_q[11:7];
    assign o_rd_data     = rd_data_q;
    assign o_mem_req     = (state_q == StMem);
    assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, reset-mid-divide sequence, then random
// instructions checked against a table-driven reference model of the sequencing rules.
module tb_alu_sequencer;

    localparam int          TMO = 40;
    localparam logic [31:0] NOP = 32'd63;

    logic        i_clk, i_rst, i_IR_valid;
    logic [31:0] i_IR;
    logic        o_fetch_req;
    logic [31:0] o_PC, o_instruction, o_IR;
    logic        o_state;
    logic        i_alu_load_regfile, i_alu_jump_DV;
    logic [31:0] i_alu_result, i_alu_jump_address;
    logic [4:0]  o_rs1, o_rs2, o_rd_addr;
    logic        o_rd_we, o_mem_req, i_mem_done, o_illegal;
    logic [31:0] o_rd_data;

    alu_sequencer dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_IR_valid         (i_IR_valid),
        .i_IR               (i_IR),
        .o_fetch_req        (o_fetch_req),
        .o_PC               (o_PC),
        .o_instruction      (o_instruction),
        .o_IR               (o_IR),
        .o_state            (o_state),
        .i_alu_load_regfile (i_alu_load_regfile),
        .i_alu_result       (i_alu_result),
        .i_alu_jump_DV      (i_alu_jump_DV),
        .i_alu_jump_address (i_alu_jump_address),
        .o_rs1              (o_rs1),
        .o_rs2              (o_rs2),
        .o_rd_we            (o_rd_we),
        .o_rd_addr          (o_rd_addr),
        .o_rd_data          (o_rd_data),
        .o_mem_req          (o_mem_req),
        .i_mem_done         (i_mem_done),
        .o_illegal          (o_illegal)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [31:0] ir;
        int          lat;   // EXEC cycle (1-based) on which the ALU strobes load_regfile
        bit          dv;
        logic [31:0] jaddr;
        logic [31:0] res;
        int          mw;    // extra MEM wait cycles before mem_done
        int          code;
        int          ex;
        int          mem;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        bit          ill;
    } vec_t;

    typedef struct {
        logic [6:0] op;
        int         f3;
        int         f7;
        int         code;
    } dec_t;

    dec_t        dec_tab[$];
    vec_t        tab[$];
    int          n_pass, n_total;
    logic [31:0] m_pc;
    bit          m_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void add_dec(input logic [6:0] op, input int f3, input int f7,
                                    input int code);
        dec_t d;
        d.op = op; d.f3 = f3; d.f7 = f7; d.code = code;
        dec_tab.push_back(d);
    endfunction

    function automatic int ref_decode(input logic [31:0] ir);
        foreach (dec_tab[i]) begin
            if (dec_tab[i].op == ir[6:0] &&
                (dec_tab[i].f3 < 0 || dec_tab[i].f3 == int'(ir[14:12])) &&
                (dec_tab[i].f7 < 0 || dec_tab[i].f7 == int'(ir[31:25])))
                return dec_tab[i].code;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input logic [31:0] ir, input int lat, input bit dv,
                                input logic [31:0] ja, input logic [31:0] res, input int mw,
                                input int code, input int ex, input int mem, input bit we,
                                input logic [31:0] data, input logic [31:0] pc, input bit ill);
        vec_t v;
        v.ir = ir; v.lat = lat; v.dv = dv; v.jaddr = ja; v.res = res; v.mw = mw;
        v.code = code; v.ex = ex; v.mem = mem; v.we = we; v.rd = ir[11:7];
        v.data = data; v.pc = pc; v.ill = ill;
        return v;
    endfunction

    // Expected outcome of one instruction from the architectural rules and current model PC.
    function automatic vec_t ref_model(input logic [31:0] ir, input int lat, input bit dv,
                                       input logic [31:0] ja, input logic [31:0] res,
                                       input int mw);
        vec_t v;
        int   code;
        code = ref_decode(ir);
        v = mk(ir, lat, dv, ja, res, mw, (code < 0) ? 0 : code, 0, 0, 1'b0, 32'd0,
               m_pc + 32'd4, m_ill);
        if (code < 0) begin
            v.ill = 1'b1;
        end else if (code >= 27 && code <= 34) begin
            v.mem = mw + 1;
        end else if (code >= 35 && code <= 40) begin
            v.ex = 2;
            if (dv) v.pc = ja;
        end else if (lat <= TMO) begin
            v.ex   = lat;
            v.we   = (ir[11:7] != 5'd0);
            v.data = res;
            if (code == 41 || code == 42) v.pc = ja;
        end else begin
            v.ex  = TMO;
            v.ill = 1'b1;
        end
        return v;
    endfunction

    task automatic wait_fetch();
        int k = 0;
        while (!o_fetch_req && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        check("fetch_req_ready", o_fetch_req, 1);
    endtask

    task automatic run(input vec_t v);
        int          exec_n = 0, mem_n = 0, we_n = 0, cyc = 0, bad = 0;
        bit          done = 0;
        bit          is_br;
        logic [4:0]  we_addr = '0;
        logic [31:0] we_data = '0;
        is_br = (v.code >= 35 && v.code <= 40);
        wait_fetch();
        check("pc_before", o_PC, m_pc);
        i_IR       = v.ir;
        i_IR_valid = 1'b1;
        @(negedge i_clk);
        check("ir_latch", o_IR, v.ir);
        check("rs_fields", {22'd0, o_rs1, o_rs2}, {22'd0, v.ir[19:15], v.ir[24:20]});
        while (!done && cyc < 100) begin
            if (o_fetch_req) begin
                done = 1;
            end else begin
                cyc++;
                if (o_state) begin
                    exec_n++;
                    if (o_instruction !== 32'(v.code)) bad++;
                end else if (o_instruction !== NOP) begin
                    bad++;
                end
                if (o_mem_req) mem_n++;
                if (o_rd_we) begin
                    we_n++;
                    we_addr = o_rd_addr;
                    we_data = o_rd_data;
                end
                // Inputs for the coming edge; IR_valid and ALU strobes get noise where ignored.
                i_IR_valid = 1'($urandom);
                i_IR       = $urandom;
                i_mem_done = o_mem_req && (mem_n == v.mw + 1);
                if (o_state) begin
                    i_alu_load_regfile = (exec_n == v.lat);
                    i_alu_jump_DV      = is_br ? v.dv : ((exec_n == v.lat) ? 1'b1 : 1'($urandom));
                    i_alu_jump_address = v.jaddr;
                    i_alu_result       = (exec_n == v.lat) ? v.res : $urandom;
                end else begin
                    i_alu_load_regfile = 1'($urandom);
                    i_alu_jump_DV      = 1'($urandom);
                    i_alu_jump_address = $urandom;
                    i_alu_result       = $urandom;
                end
                @(negedge i_clk);
            end
        end
        i_IR_valid = 1'b0;
        i_mem_done = 1'b0;
        check("back_to_idle", 32'(done), 1);
        check("cycles", cyc, 2 + v.ex + v.mem);
        check("exec_cycles", exec_n, v.ex);
        check("mem_cycles", mem_n, v.mem);
        check("rd_we_pulses", we_n, 32'(v.we));
        if (v.we) begin
            check("rd_addr", 32'(we_addr), 32'(v.rd));
            check("rd_data", we_data, v.data);
        end
        check("instr_code_bad_cycles", bad, 0);
        check("pc_after", o_PC, v.pc);
        check("illegal", 32'(o_illegal), 32'(v.ill));
        m_pc  = v.pc;
        m_ill = v.ill;
    endtask

    initial begin
        int          n, k, we_seen;
        logic [31:0] w;
        int          lat, r;
        logic [31:0] ja;
        vec_t        v;

        n_pass = 0; n_total = 0; m_pc = 32'h0; m_ill = 1'b0;
        i_rst = 1'b1; i_IR_valid = 1'b0; i_IR = '0; i_alu_load_regfile = 1'b0;
        i_alu_result = '0; i_alu_jump_DV = 1'b0; i_alu_jump_address = '0; i_mem_done = 1'b0;

        add_dec(7'h33, 0, 0, 0);   add_dec(7'h33, 0, 32, 1);  add_dec(7'h33, 1, 0, 2);
        add_dec(7'h33, 2, 0, 3);   add_dec(7'h33, 3, 0, 4);   add_dec(7'h33, 4, 0, 5);
        add_dec(7'h33, 5, 0, 6);   add_dec(7'h33, 5, 32, 7);  add_dec(7'h33, 6, 0, 8);
        add_dec(7'h33, 7, 0, 9);
        for (int f = 0; f < 8; f++) add_dec(7'h33, f, 1, 10 + f);
        add_dec(7'h13, 0, -1, 18); add_dec(7'h13, 2, -1, 19); add_dec(7'h13, 3, -1, 20);
        add_dec(7'h13, 4, -1, 21); add_dec(7'h13, 6, -1, 22); add_dec(7'h13, 7, -1, 23);
        add_dec(7'h13, 1, 0, 24);  add_dec(7'h13, 5, 0, 25);  add_dec(7'h13, 5, 32, 26);
        add_dec(7'h03, 0, -1, 27); add_dec(7'h03, 1, -1, 28); add_dec(7'h03, 2, -1, 29);
        add_dec(7'h03, 4, -1, 30); add_dec(7'h03, 5, -1, 31);
        add_dec(7'h23, 0, -1, 32); add_dec(7'h23, 1, -1, 33); add_dec(7'h23, 2, -1, 34);
        add_dec(7'h63, 0, -1, 35); add_dec(7'h63, 1, -1, 36); add_dec(7'h63, 4, -1, 37);
        add_dec(7'h63, 5, -1, 38); add_dec(7'h63, 6, -1, 39); add_dec(7'h63, 7, -1, 40);
        add_dec(7'h6f, -1, -1, 41); add_dec(7'h67, 0, -1, 42);
        add_dec(7'h37, -1, -1, 43); add_dec(7'h17, -1, -1, 44);

        //          ir            lat dv jaddr         res      mw code ex mem we data   pc           ill
        tab.push_back(mk(32'h00700293, 1, 0, 32'h0,        32'd7,   0, 18, 1, 0, 1, 32'd7,  32'h4,       0));
        tab.push_back(mk(32'h0000006F, 1, 1, 32'h100,      32'h8,   0, 41, 1, 0, 0, 32'd0,  32'h100,     0));
        tab.push_back(mk(32'h00000063, 1, 1, 32'h0F8,      32'h0,   0, 35, 2, 0, 0, 32'd0,  32'h0F8,     0));
        tab.push_back(mk(32'h0000006F, 1, 1, 32'h100,      32'h0,   0, 41, 1, 0, 0, 32'd0,  32'h100,     0));
        tab.push_back(mk(32'h00000063, 1, 0, 32'h0F8,      32'h0,   0, 35, 2, 0, 0, 32'd0,  32'h104,     0));
        tab.push_back(mk(32'h0000006F, 1, 1, 32'h20,       32'h0,   0, 41, 1, 0, 0, 32'd0,  32'h20,      0));
        tab.push_back(mk(32'h000000EF, 1, 1, 32'h80,       32'h24,  0, 41, 1, 0, 1, 32'h24, 32'h80,      0));
        tab.push_back(mk(32'h0220C1B3, 26, 0, 32'h0,       32'hDEAD,0, 14, 26,0, 1, 32'hDEAD,32'h84,     0));
        tab.push_back(mk(32'h0000A203, 1, 0, 32'h0,        32'h0,   3, 29, 0, 4, 0, 32'd0,  32'h88,      0));
        tab.push_back(mk(32'h0020A023, 1, 0, 32'h0,        32'h0,   0, 34, 0, 1, 0, 32'd0,  32'h8C,      0));
        tab.push_back(mk(32'h00100313, 40, 0, 32'h0,       32'h55,  0, 18, 40,0, 1, 32'h55, 32'h90,      0));
        tab.push_back(mk(32'h00100313, 41, 0, 32'h0,       32'h55,  0, 18, 40,0, 0, 32'd0,  32'h94,      1));
        tab.push_back(mk(32'hFFFFFFFF, 1, 0, 32'h0,        32'h0,   0, 0,  0, 0, 0, 32'd0,  32'h98,      1));
        tab.push_back(mk(32'h00208033, 1, 0, 32'h0,        32'd5,   0, 0,  1, 0, 0, 32'd0,  32'h9C,      1));
        tab.push_back(mk(32'h0000006F, 1, 1, 32'hFFFFFFFC, 32'h0,   0, 41, 1, 0, 0, 32'd0,  32'hFFFFFFFC,1));
        tab.push_back(mk(32'h00700293, 1, 0, 32'h0,        32'd7,   0, 18, 1, 0, 1, 32'd7,  32'h0,       1));

        repeat (3) @(negedge i_clk);
        check("rst_fetch_req", 32'(o_fetch_req), 1);
        check("rst_pc", o_PC, 32'h0);
        check("rst_state", 32'(o_state), 0);
        check("rst_instruction", o_instruction, NOP);
        check("rst_ir", o_IR, 32'h0);
        check("rst_flags", {29'd0, o_rd_we, o_mem_req, o_illegal}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        foreach (tab[i]) run(tab[i]);

        // Reset landing in the middle of a divide (cnt == 10, i.e. 11th EXEC cycle).
        wait_fetch();
        i_IR = 32'h0220C1B3;
        i_IR_valid = 1'b1;
        @(negedge i_clk);
        i_IR_valid = 1'b0;
        i_alu_load_regfile = 1'b0;
        n = 0; k = 0; we_seen = 0;
        while (k < 60) begin
            if (o_state) n++;
            if (o_rd_we) we_seen++;
            if (n == 11) break;
            @(negedge i_clk);
            k++;
        end
        check("div_reached_cnt10", n, 11);
        check("div_code", o_instruction, 32'd14);
        i_rst = 1'b1;
        i_alu_load_regfile = 1'b1;
        i_alu_jump_DV = 1'b1;
        i_alu_result = 32'h1234;
        @(negedge i_clk);
        check("midrst_fetch_req", 32'(o_fetch_req), 1);
        check("midrst_state", 32'(o_state), 0);
        check("midrst_pc", o_PC, 32'h0);
        check("midrst_ir", o_IR, 32'h0);
        check("midrst_instruction", o_instruction, NOP);
        check("midrst_illegal_cleared", 32'(o_illegal), 0);
        if (o_rd_we) we_seen++;
        repeat (2) begin @(negedge i_clk); if (o_rd_we) we_seen++; end
        i_rst = 1'b0;
        repeat (4) begin @(negedge i_clk); if (o_rd_we) we_seen++; end
        i_alu_load_regfile = 1'b0;
        check("midrst_no_write", we_seen, 0);
        check("midrst_still_idle", {31'd0, o_fetch_req}, 1);
        m_pc = 32'h0;
        m_ill = 1'b0;

        for (int t = 0; t < 150; t++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                k = $urandom_range(0, dec_tab.size() - 1);
                w[6:0] = dec_tab[k].op;
                if (dec_tab[k].f3 >= 0) w[14:12] = 3'(dec_tab[k].f3);
                if (dec_tab[k].f7 >= 0) w[31:25] = 7'(dec_tab[k].f7);
            end
            r = $urandom_range(0, 9);
            if (r < 6) lat = 1;
            else if (r < 8) lat = 26;
            else if (r == 8) lat = $urandom_range(2, 45);
            else lat = TMO + 1;
            ja = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            v = ref_model(w, lat, 1'($urandom), ja, $urandom, $urandom_range(0, 3));
            run(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
